// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DIGITS  = 4;
  localparam int DIGIT_W = 4;

  // Digits at or above this value get +3 before each shift.
  localparam logic [DIGIT_W-1:0] ADD3_THRESH = 4'd5;

  // Result presented on overflow when saturation is enabled.
  localparam logic [DIGITS*DIGIT_W-1:0] BCD_MAX = 16'h9999;

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is 5 or more,
// so that the following left shift carries correctly into the next digit.
module bcd_add3_digit
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] din,
  output logic [DIGIT_W-1:0] dout
);

  // Conditional +3 correction
  always_comb begin
    dout = din;
    if (din >= ADD3_THRESH) begin
      dout = din + DIGIT_W'(3);
    end
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential 14-bit binary to 4-digit packed BCD converter (double dabble,
// one shift per clock). A fifth, internal ten-thousands digit drives the
// overflow flag.
// Build option: define BIN_TO_BCD_SAT_EN to saturate bcd to 9999 on overflow;
// otherwise bcd carries the low four digits (bin mod 10000).
//
// state | meaning
// IDLE  | waiting for in_valid; in_ready=1
// SHIFT | BIN_W double-dabble steps, then one cycle to register the result
// DONE  | result held on bcd/overflow with out_valid=1 until out_ready
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int BIN_W = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BIN_W-1:0] bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      bcd,
  output logic             overflow
);

  localparam int CNT_W    = $clog2(BIN_W + 1);
  localparam int NDIG     = DIGITS + 1;
  localparam int DIG_BITS = NDIG * DIGIT_W;
  localparam int OUT_BITS = DIGITS * DIGIT_W;

  state_t               state;
  state_t               state_nx;
  logic [CNT_W-1:0]     cnt;
  logic [DIG_BITS-1:0]  dig;
  logic [DIG_BITS-1:0]  adj;
  logic [BIN_W-1:0]     sh;
  logic [DIG_BITS+BIN_W-1:0] stepped;
  logic                 accept;
  logic                 last_step;
  logic                 ovf_w;
  logic [OUT_BITS-1:0]  result;

  for (genvar g = 0; g < NDIG; g++) begin : g_add3
    bcd_add3_digit u_add3 (
      .din  (dig[g*DIGIT_W +: DIGIT_W]),
      .dout (adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  assign stepped   = {adj, sh} << 1;
  assign accept    = in_valid && in_ready;
  assign last_step = (cnt == CNT_W'(BIN_W));
  assign ovf_w     = (dig[DIG_BITS-1 -: DIGIT_W] != '0);

`ifdef BIN_TO_BCD_SAT_EN
  assign result = ovf_w ? BCD_MAX : dig[OUT_BITS-1:0];
`else
  assign result = dig[OUT_BITS-1:0];
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (last_step) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: load on accept, shift while counting, register result last
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      dig      <= '0;
      sh       <= '0;
      bcd      <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            sh  <= bin;
            dig <= '0;
            cnt <= '0;
          end
        end
        SHIFT: begin
          if (!last_step) begin
            dig <= stepped[DIG_BITS+BIN_W-1 -: DIG_BITS];
            sh  <= stepped[BIN_W-1:0];
            cnt <= cnt + CNT_W'(1);
          end else begin
            bcd      <= result;
            overflow <= ovf_w;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Self-checking bench for bin_to_bcd_seq: directed table, handshake corner
// sequences, and random pairs summed by a downstream BCD adder.
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready, overflow;
  logic [13:0] bin;
  logic [15:0] bcd;
  logic        in_valid2, in_ready2, out_valid2, out_ready2, overflow2;
  logic [13:0] bin2;
  logic [15:0] bcd2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [13:0] bin;
    logic [15:0] low;   // BCD of bin mod 10000
    logic        ovf;
  } vec_t;

  vec_t vecs[12];

  bin_to_bcd_seq #(.BIN_W(14)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
    .bcd(bcd), .overflow(overflow)
  );

  bin_to_bcd_seq #(.BIN_W(14)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
    .bin(bin2), .out_valid(out_valid2), .out_ready(out_ready2),
    .bcd(bcd2), .overflow(overflow2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: decimal digits from plain arithmetic
  function automatic logic [19:0] enc5(input int v);
    return {4'(v / 10000 % 10), 4'(v / 1000 % 10), 4'(v / 100 % 10),
            4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [15:0] exp_bcd(input int v);
    logic [19:0] e;
`ifdef BIN_TO_BCD_SAT_EN
    if (v > 9999) return 16'h9999;
`endif
    e = enc5(v % 10000);
    return e[15:0];
  endfunction

  // Downstream 4-digit BCD adder with carry-out digit
  function automatic logic [19:0] bcd_add(input logic [15:0] a, input logic [15:0] b);
    logic [19:0] s;
    int c;
    int d;
    c = 0;
    s = '0;
    for (int i = 0; i < 4; i++) begin
      d = int'(a[i*4 +: 4]) + int'(b[i*4 +: 4]) + c;
      if (d > 9) begin d = d - 10; c = 1; end else c = 0;
      s[i*4 +: 4] = 4'(d);
    end
    s[19:16] = 4'(c);
    return s;
  endfunction

  // Called just after the accepting edge; counts edges until out_valid
  task automatic wait_result(output logic [15:0] r, output logic o, output int lat,
                             output bit rdy_seen);
    lat = 0;
    rdy_seen = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (in_ready) rdy_seen = 1;
    end while (!out_valid && lat < 40);
    r = bcd;
    o = overflow;
  endtask

  task automatic run_conv(input logic [13:0] b, output logic [15:0] r, output logic o,
                          output int lat);
    bit rs;
    @(negedge clk);
    chk("ready_before_accept", 32'(in_ready), 32'd1);
    bin = b;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_result(r, o, lat, rs);
    @(posedge clk);
    #1;
    chk("ready_after_consume", 32'(in_ready), 32'd1);
  endtask

  logic [15:0] r, r2;
  logic        o, o2;
  int          lat;
  bit          rs;
  bit          seen;
  int          a, b;

  initial begin
    vecs[0]  = '{14'd0,     16'h0000, 1'b0};
    vecs[1]  = '{14'd9999,  16'h9999, 1'b0};
    vecs[2]  = '{14'd10000, 16'h0000, 1'b1};
    vecs[3]  = '{14'd12345, 16'h2345, 1'b1};
    vecs[4]  = '{14'd16383, 16'h6383, 1'b1};
    vecs[5]  = '{14'd1,     16'h0001, 1'b0};
    vecs[6]  = '{14'd5,     16'h0005, 1'b0};
    vecs[7]  = '{14'd10,    16'h0010, 1'b0};
    vecs[8]  = '{14'd507,   16'h0507, 1'b0};
    vecs[9]  = '{14'd8765,  16'h8765, 1'b0};
    vecs[10] = '{14'd1000,  16'h1000, 1'b0};
    vecs[11] = '{14'd10999, 16'h0999, 1'b1};

    reset = 1'b1;
    in_valid = 1'b0; bin = '0; out_ready = 1'b1;
    in_valid2 = 1'b0; bin2 = '0; out_ready2 = 1'b1;

    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_bcd", 32'(bcd), 32'h0);
    chk("rst_overflow", 32'(overflow), 32'd0);

    // First acceptance at the first edge after reset release
    @(negedge clk);
    bin = 14'd1234;
    in_valid = 1'b1;
    reset = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_result(r, o, lat, rs);
    chk("first_latency", 32'(lat), 32'd15);
    chk("first_bcd", 32'(r), 32'h1234);
    chk("first_ovf", 32'(o), 32'd0);
    chk("first_ready_during", 32'(rs), 32'd0);
    @(posedge clk);
    #1 chk("first_ready_next", 32'(in_ready), 32'd1);

    // Back-to-back 0 then 9999 with in_valid held high throughout
    @(negedge clk);
    bin = 14'd0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 bin = 14'd9999;
    wait_result(r, o, lat, rs);
    chk("b2b0_bcd", 32'(r), 32'h0000);
    chk("b2b0_ovf", 32'(o), 32'd0);
    chk("b2b0_latency", 32'(lat), 32'd15);
    chk("b2b0_not_ready", 32'(rs), 32'd0);
    @(posedge clk);
    #1 chk("b2b_idle_between", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    chk("b2b1_accepted", 32'(in_ready), 32'd0);
    wait_result(r, o, lat, rs);
    chk("b2b1_bcd", 32'(r), 32'h9999);
    chk("b2b1_ovf", 32'(o), 32'd0);
    chk("b2b1_latency", 32'(lat), 32'd15);
    @(posedge clk);

    // Directed table
    for (int i = 0; i < 12; i++) begin
      run_conv(vecs[i].bin, r, o, lat);
`ifdef BIN_TO_BCD_SAT_EN
      chk("tbl_bcd", 32'(r), vecs[i].ovf ? 32'h9999 : 32'(vecs[i].low));
`else
      chk("tbl_bcd", 32'(r), 32'(vecs[i].low));
`endif
      chk("tbl_ovf", 32'(o), 32'(vecs[i].ovf));
      chk("tbl_latency", 32'(lat), 32'd15);
    end

    // Result held under backpressure; input in DONE is ignored
    @(negedge clk);
    bin = 14'd507;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    wait_result(r, o, lat, rs);
    chk("hold_first_bcd", 32'(r), 32'h0507);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 3) begin in_valid = 1'b1; bin = 14'd1234; end
      if (i == 6) in_valid = 1'b0;
      chk("hold_bcd", 32'(bcd), 32'h0507);
      chk("hold_ovf", 32'(overflow), 32'd0);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("hold_release_ready", 32'(in_ready), 32'd1);
    chk("hold_release_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1 chk("hold_ignored_input", 32'(in_ready), 32'd1);

    // Reset mid-SHIFT discards the conversion
    @(negedge clk);
    bin = 14'd4321;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("midrst_ready", 32'(in_ready), 32'd1);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_bcd", 32'(bcd), 32'h0);
    chk("midrst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (25) begin
      @(posedge clk);
      #1 if (out_valid) seen = 1;
    end
    chk("midrst_no_valid", 32'(seen), 32'd0);
    run_conv(14'd88, r, o, lat);
    chk("after_rst_bcd", 32'(r), 32'h0088);
    chk("after_rst_ovf", 32'(o), 32'd0);

    // Random pairs through two converters and the BCD adder
    for (int n = 0; n < 200; n++) begin
      a = int'($urandom_range(9999, 0));
      b = int'($urandom_range(9999, 0));
      @(negedge clk);
      bin = 14'(a); bin2 = 14'(b);
      in_valid = 1'b1; in_valid2 = 1'b1;
      @(posedge clk);
      #1 begin in_valid = 1'b0; in_valid2 = 1'b0; end
      lat = 0;
      do begin
        @(posedge clk);
        #1 lat++;
      end while (!(out_valid && out_valid2) && lat < 40);
      chk("rnd_latency", 32'(lat), 32'd15);
      chk("rnd_a_bcd", 32'(bcd), 32'(exp_bcd(a)));
      chk("rnd_sum", 32'(bcd_add(bcd, bcd2)), 32'(enc5(a + b)));
      @(posedge clk);
    end

    // Random full-range operands against the model, including overflow
    for (int n = 0; n < 40; n++) begin
      a = int'($urandom_range(16383, 0));
      run_conv(14'(a), r, o, lat);
      chk("rnd_full_bcd", 32'(r), 32'(exp_bcd(a)));
      chk("rnd_full_ovf", 32'(o), 32'(a > 9999));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
